// File: rtl/bsg_channel_widen.sv
// Narrow-to-wide channel stage: gathers els_p narrow chunks (chunk 0 = LSB slice) into one wide
// word, with one assembly register and one registered output word.
module bsg_channel_widen #(
  parameter int unsigned width_in_p = 8,
  parameter int unsigned els_p      = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        v_i,
  input  logic [width_in_p-1:0]       data_i,
  output logic                        ready_o,
  output logic                        v_o,
  output logic [width_in_p*els_p-1:0] data_o,
  input  logic                        yumi_i
);

  localparam int unsigned count_w_lp = $clog2(els_p);
  localparam int unsigned asm_w_lp   = (els_p - 1) * width_in_p;
  localparam logic [count_w_lp-1:0] last_lp = count_w_lp'(els_p - 1);

  logic [count_w_lp-1:0]         count_r;
  logic [asm_w_lp-1:0]           asm_r, asm_n;
  logic [width_in_p*els_p-1:0]   out_r;
  logic                          out_v_r;
  logic                          last, accept;

  assign last    = (count_r == last_lp);
  // yumi_i frees the output slot in the same cycle, so the final chunk can land with no bubble.
  assign ready_o = ~last | ~out_v_r | yumi_i;
  assign accept  = v_i & ready_o;
  assign v_o     = out_v_r;
  assign data_o  = out_r;

  always_comb begin
    asm_n = asm_r;
    for (int i = 0; i < int'(els_p) - 1; i++) begin
      if (count_r == count_w_lp'(i)) begin
        asm_n[i*width_in_p +: width_in_p] = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r <= '0;
      asm_r   <= '0;
      out_r   <= '0;
      out_v_r <= 1'b0;
    end else if (accept && last) begin
      out_r   <= {data_i, asm_r};
      out_v_r <= 1'b1;
      count_r <= '0;
    end else begin
      if (yumi_i) begin
        out_v_r <= 1'b0;
      end
      if (accept) begin
        asm_r   <= asm_n;
        count_r <= count_r + count_w_lp'(1);
      end
    end
  end

`ifndef SYNTHESIS
  if (els_p < 2) begin : g_bad_els
    $error("bsg_channel_widen: els_p must be at least 2");
  end

  yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
    else $error("bsg_channel_widen: yumi_i asserted while v_o is low");
`endif

endmodule

// File: tb/tb_bsg_channel_widen.sv
// Directed bench for bsg_channel_widen: default 8x2 instance plus a 4x4 instance.
module tb_bsg_channel_widen;

  logic        clk = 1'b0;
  logic        reset;
  logic        v, yumi, ready, v_o;
  logic [7:0]  data;
  logic [15:0] data_o;

  logic        v4, yumi4, ready4, v_o4;
  logic [3:0]  data4;
  logic [15:0] data_o4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bsg_channel_widen #(.width_in_p(8), .els_p(2)) dut (
    .clk_i(clk), .reset_i(reset), .v_i(v), .data_i(data), .ready_o(ready),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi)
  );

  bsg_channel_widen #(.width_in_p(4), .els_p(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .v_i(v4), .data_i(data4), .ready_o(ready4),
    .v_o(v_o4), .data_o(data_o4), .yumi_i(yumi4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one chunk at the falling edge, then sample just after the rising edge.
  task automatic send(input logic vv, input logic [7:0] d, input logic y);
    @(negedge clk);
    v = vv; data = d; yumi = y;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_word;

  initial begin
    reset = 1'b1; v = 1'b0; data = '0; yumi = 1'b0;
    v4 = 1'b0; data4 = '0; yumi4 = 1'b0;
    #3;
    check_eq("rst_v", v_o, 0);
    check_eq("rst_data", data_o, 16'h0000);
    check_eq("rst_ready", ready, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_rst_v", v_o, 0);
    check_eq("post_rst_ready", ready, 1);

    // Basic assembly
    send(1, 8'hA5, 0);
    check_eq("basic_v_mid", v_o, 0);
    send(1, 8'h3C, 0);
    check_eq("basic_v", v_o, 1);
    check_eq("basic_data", data_o, 16'h3CA5);
    send(0, 8'h00, 0);
    check_eq("basic_hold_v", v_o, 1);
    check_eq("basic_hold_data", data_o, 16'h3CA5);

    // Streaming with yumi whenever v_o is high
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      v = 1'b1; data = 8'(k); yumi = v_o;
      #1;
      check_eq($sformatf("stream_ready_%0d", k), ready, 1);
      @(posedge clk);
      #1;
      if (k % 2 == 0) begin
        exp_word = {8'(k), 8'(k - 1)};
        check_eq($sformatf("stream_v_%0d", k), v_o, 1);
        check_eq($sformatf("stream_data_%0d", k), data_o, exp_word);
      end
    end

    // Backpressure: retire 0605, load 1111, then stall chunk 33
    send(1, 8'h11, 1);
    send(1, 8'h11, 0);
    check_eq("bp_hold_data", data_o, 16'h1111);
    @(negedge clk);
    v = 1'b1; data = 8'h22; yumi = 1'b0;
    #1;
    check_eq("bp_ready_22", ready, 1);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      v = 1'b1; data = 8'h33; yumi = 1'b0;
      #1;
      check_eq($sformatf("bp_stall_ready_%0d", c), ready, 0);
      @(posedge clk);
      #1;
      check_eq($sformatf("bp_stall_data_%0d", c), data_o, 16'h1111);
    end
    @(negedge clk);
    yumi = 1'b1;
    #1;
    check_eq("bp_yumi_ready", ready, 1);
    @(posedge clk);
    #1;
    check_eq("bp_new_v", v_o, 1);
    check_eq("bp_new_data", data_o, 16'h3322);

    // Reset mid-word discards the partial chunk
    send(1, 8'h77, 1);
    @(negedge clk);
    v = 1'b0; yumi = 1'b0; reset = 1'b1;
    #1;
    check_eq("mid_rst_v", v_o, 0);
    check_eq("mid_rst_data", data_o, 16'h0000);
    check_eq("mid_rst_ready", ready, 1);
    @(negedge clk);
    reset = 1'b0;
    send(1, 8'h10, 0);
    send(1, 8'h20, 0);
    check_eq("mid_rst_word_v", v_o, 1);
    check_eq("mid_rst_word", data_o, 16'h2010);
    send(0, 8'h00, 0);

    // 4-bit x 4 instance
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      v4 = 1'b1; data4 = 4'(n); yumi4 = (n == 5);
      @(posedge clk);
      #1;
      if (n == 4) begin
        check_eq("w4_v", v_o4, 1);
        check_eq("w4_data", data_o4, 16'h4321);
      end else if (n == 6) begin
        check_eq("w4_drained_v", v_o4, 0);
      end else if (n == 8) begin
        check_eq("w4_next_v", v_o4, 1);
        check_eq("w4_next_data", data_o4, 16'h8765);
      end
    end
    @(negedge clk);
    v4 = 1'b0; yumi4 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
